// File: rtl/sha2_round_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha2_round_engine: SHA-256/512 compression, UNROLL rounds per clock.      |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
module sha2_round_engine #(
   parameter int WORDSIZE = 32,
   parameter int ROUNDS   = 64,
   parameter int UNROLL   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_valid,
   output logic                         start_ready,
   input  logic [16*WORDSIZE-1:0]       block_in,
   input  logic [8*WORDSIZE-1:0]        hash_in,
   output logic [6:0]                   round_idx,
   input  logic [UNROLL*WORDSIZE-1:0]   k_in,
   input  logic                         abort,
   output logic                         digest_valid,
   input  logic                         digest_ready,
   output logic [8*WORDSIZE-1:0]        digest_out,
   output logic                         busy
);
   typedef logic [WORDSIZE-1:0] word_t;

   localparam logic [1:0] C_IDLE  = 2'd0;
   localparam logic [1:0] C_ROUND = 2'd1;
   localparam logic [1:0] C_FINAL = 2'd2;
   localparam logic [1:0] C_DONE  = 2'd3;

   localparam logic [6:0] C_STEP = 7'(UNROLL);
   localparam logic [6:0] C_LAST = 7'(ROUNDS - UNROLL);

   localparam bit C_W64   = (WORDSIZE == 64);
   localparam int C_BS0_A = C_W64 ? 28 : 2;
   localparam int C_BS0_B = C_W64 ? 34 : 13;
   localparam int C_BS0_C = C_W64 ? 39 : 22;
   localparam int C_BS1_A = C_W64 ? 14 : 6;
   localparam int C_BS1_B = C_W64 ? 18 : 11;
   localparam int C_BS1_C = C_W64 ? 41 : 25;
   localparam int C_SS0_A = C_W64 ? 1  : 7;
   localparam int C_SS0_B = C_W64 ? 8  : 18;
   localparam int C_SS0_C = C_W64 ? 7  : 3;
   localparam int C_SS1_A = C_W64 ? 19 : 17;
   localparam int C_SS1_B = C_W64 ? 61 : 19;
   localparam int C_SS1_C = C_W64 ? 6  : 10;

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (WORDSIZE - n));
   endfunction

   function automatic word_t bsig0(input word_t x);
      return rotr(x, C_BS0_A) ^ rotr(x, C_BS0_B) ^ rotr(x, C_BS0_C);
   endfunction

   function automatic word_t bsig1(input word_t x);
      return rotr(x, C_BS1_A) ^ rotr(x, C_BS1_B) ^ rotr(x, C_BS1_C);
   endfunction

   function automatic word_t ssig0(input word_t x);
      return rotr(x, C_SS0_A) ^ rotr(x, C_SS0_B) ^ (x >> C_SS0_C);
   endfunction

   function automatic word_t ssig1(input word_t x);
      return rotr(x, C_SS1_A) ^ rotr(x, C_SS1_B) ^ (x >> C_SS1_C);
   endfunction

   logic [1:0] state_q, state_d;
   logic [6:0] rnd_q;
   word_t      hash_q [8];
   word_t      work_q [8];
   word_t      win_q  [16];
   word_t      dig_q  [8];

   word_t      w_blk  [16];
   word_t      w_hash [8];
   word_t      w_ext  [16+UNROLL];
   word_t      w_st   [UNROLL+1][8];

   for (genvar j = 0; j < 16; j++) begin : g_blk
      assign w_blk[j] = block_in[(15-j)*WORDSIZE +: WORDSIZE];
   end

   for (genvar j = 0; j < 8; j++) begin : g_hash
      assign w_hash[j] = hash_in[(7-j)*WORDSIZE +: WORDSIZE];
      assign digest_out[(7-j)*WORDSIZE +: WORDSIZE] = dig_q[j];
   end

   // Schedule words beyond the window are generated on the fly; the window then slides by UNROLL.
   always_comb begin
      word_t t1, t2;
      t1 = '0;
      t2 = '0;
      for (int j = 0; j < 16; j++) w_ext[j] = win_q[j];
      for (int j = 0; j < UNROLL; j++)
         w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
      for (int j = 0; j < 8; j++) w_st[0][j] = work_q[j];
      for (int i = 0; i < UNROLL; i++) begin
         t1 = w_st[i][7] + bsig1(w_st[i][4])
            + ((w_st[i][4] & w_st[i][5]) ^ (~w_st[i][4] & w_st[i][6]))
            + k_in[i*WORDSIZE +: WORDSIZE] + w_ext[i];
         t2 = bsig0(w_st[i][0])
            + ((w_st[i][0] & w_st[i][1]) ^ (w_st[i][0] & w_st[i][2]) ^ (w_st[i][1] & w_st[i][2]));
         w_st[i+1][0] = t1 + t2;
         w_st[i+1][1] = w_st[i][0];
         w_st[i+1][2] = w_st[i][1];
         w_st[i+1][3] = w_st[i][2];
         w_st[i+1][4] = w_st[i][3] + t1;
         w_st[i+1][5] = w_st[i][4];
         w_st[i+1][6] = w_st[i][5];
         w_st[i+1][7] = w_st[i][6];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= C_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         C_IDLE:  if (start_valid) state_d = C_ROUND;
         C_ROUND: if (abort) state_d = C_IDLE;
                  else if (rnd_q == C_LAST) state_d = C_FINAL;
         C_FINAL: state_d = abort ? C_IDLE : C_DONE;
         C_DONE:  if (digest_ready) state_d = C_IDLE;
         default: state_d = C_IDLE;
      endcase
   end

   always_comb begin
      start_ready  = (state_q == C_IDLE);
      busy         = (state_q != C_IDLE);
      digest_valid = (state_q == C_DONE);
      round_idx    = (state_q == C_ROUND) ? rnd_q : 7'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnd_q <= '0;
         for (int j = 0; j < 8; j++) begin
            hash_q[j] <= '0;
            work_q[j] <= '0;
            dig_q[j]  <= '0;
         end
         for (int j = 0; j < 16; j++) win_q[j] <= '0;
      end else begin
         case (state_q)
            C_IDLE: if (start_valid) begin
               rnd_q <= '0;
               for (int j = 0; j < 8; j++) begin
                  hash_q[j] <= w_hash[j];
                  work_q[j] <= w_hash[j];
               end
               for (int j = 0; j < 16; j++) win_q[j] <= w_blk[j];
            end
            C_ROUND: if (!abort) begin
               rnd_q <= rnd_q + C_STEP;
               for (int j = 0; j < 8; j++) work_q[j] <= w_st[UNROLL][j];
               for (int j = 0; j < 16; j++) win_q[j] <= w_ext[UNROLL+j];
            end
            C_FINAL: if (!abort) begin
               for (int j = 0; j < 8; j++) dig_q[j] <= hash_q[j] + work_q[j];
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sha2_round_engine.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for sha2_round_engine: a SHA-256/1-round and a SHA-512/4-round engine
// checked against a plain-arithmetic SHA-2 compression model.
module tb_sha2_round_engine;
   typedef logic [7:0][63:0]  hv_t;
   typedef logic [15:0][63:0] blk_t;

   localparam logic [63:0] K512 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

   localparam logic [63:0] IV512 [8] = '{
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         s32_sv = 0, s32_sr, s32_abort = 0, s32_dv, s32_dr = 0, s32_busy;
   logic [511:0] s32_blk = '0;
   logic [255:0] s32_h = '0, s32_dout;
   logic [6:0]   s32_ridx;
   logic [31:0]  s32_k;

   logic          s64_sv = 0, s64_sr, s64_abort = 0, s64_dv, s64_dr = 0, s64_busy;
   logic [1023:0] s64_blk = '0;
   logic [511:0]  s64_h = '0, s64_dout;
   logic [6:0]    s64_ridx;
   logic [255:0]  s64_k;

   int n_cmp = 0;
   int n_fail = 0;

   sha2_round_engine #(.WORDSIZE(32), .ROUNDS(64), .UNROLL(1)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start_valid(s32_sv), .start_ready(s32_sr),
      .block_in(s32_blk), .hash_in(s32_h), .round_idx(s32_ridx), .k_in(s32_k),
      .abort(s32_abort), .digest_valid(s32_dv), .digest_ready(s32_dr),
      .digest_out(s32_dout), .busy(s32_busy));

   sha2_round_engine #(.WORDSIZE(64), .ROUNDS(80), .UNROLL(4)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .start_valid(s64_sv), .start_ready(s64_sr),
      .block_in(s64_blk), .hash_in(s64_h), .round_idx(s64_ridx), .k_in(s64_k),
      .abort(s64_abort), .digest_valid(s64_dv), .digest_ready(s64_dr),
      .digest_out(s64_dout), .busy(s64_busy));

   // External K ROMs
   always_comb begin
      s32_k = (int'(s32_ridx) < 64) ? K512[int'(s32_ridx)][63:32] : 32'h0;
      s64_k = '0;
      for (int i = 0; i < 4; i++)
         if (int'(s64_ridx) + i < 80) s64_k[i*64 +: 64] = K512[int'(s64_ridx) + i];
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ws);
      if (ws == 32) return {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic hv_t ref_compress(input int ws, input hv_t h, input blk_t m);
      logic [63:0] w [80];
      logic [63:0] v [8];
      logic [63:0] mask, s0, s1, ch, mj, k, t1, t2;
      int rounds;
      hv_t r;
      mask   = (ws == 32) ? 64'hffff_ffff : 64'hffff_ffff_ffff_ffff;
      rounds = (ws == 32) ? 64 : 80;
      for (int t = 0; t < 16; t++) w[t] = m[t] & mask;
      for (int t = 16; t < 80; t++) w[t] = '0;
      for (int t = 16; t < rounds; t++) begin
         if (ws == 32) begin
            s0 = rotr(w[t-15], 7, 32) ^ rotr(w[t-15], 18, 32) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17, 32) ^ rotr(w[t-2], 19, 32) ^ (w[t-2] >> 10);
         end else begin
            s0 = rotr(w[t-15], 1, 64) ^ rotr(w[t-15], 8, 64) ^ (w[t-15] >> 7);
            s1 = rotr(w[t-2], 19, 64) ^ rotr(w[t-2], 61, 64) ^ (w[t-2] >> 6);
         end
         w[t] = (s1 + w[t-7] + s0 + w[t-16]) & mask;
      end
      for (int j = 0; j < 8; j++) v[j] = h[j] & mask;
      for (int t = 0; t < rounds; t++) begin
         if (ws == 32) begin
            s1 = rotr(v[4], 6, 32) ^ rotr(v[4], 11, 32) ^ rotr(v[4], 25, 32);
            s0 = rotr(v[0], 2, 32) ^ rotr(v[0], 13, 32) ^ rotr(v[0], 22, 32);
            k  = {32'h0, K512[t][63:32]};
         end else begin
            s1 = rotr(v[4], 14, 64) ^ rotr(v[4], 18, 64) ^ rotr(v[4], 41, 64);
            s0 = rotr(v[0], 28, 64) ^ rotr(v[0], 34, 64) ^ rotr(v[0], 39, 64);
            k  = K512[t];
         end
         ch = ((v[4] & v[5]) ^ (~v[4] & v[6])) & mask;
         mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
         t1 = (v[7] + s1 + ch + k + w[t]) & mask;
         t2 = (s0 + mj) & mask;
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4];
         v[4] = (v[3] + t1) & mask;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0];
         v[0] = (t1 + t2) & mask;
      end
      for (int j = 0; j < 8; j++) r[j] = (h[j] + v[j]) & mask;
      return r;
   endfunction

   // ---------------- packing helpers ----------------
   function automatic logic [511:0] pk_blk32(input blk_t m);
      logic [511:0] r;
      for (int j = 0; j < 16; j++) r[(15-j)*32 +: 32] = m[j][31:0];
      return r;
   endfunction
   function automatic logic [1023:0] pk_blk64(input blk_t m);
      logic [1023:0] r;
      for (int j = 0; j < 16; j++) r[(15-j)*64 +: 64] = m[j];
      return r;
   endfunction
   function automatic logic [255:0] pk_h32(input hv_t h);
      logic [255:0] r;
      for (int j = 0; j < 8; j++) r[(7-j)*32 +: 32] = h[j][31:0];
      return r;
   endfunction
   function automatic logic [511:0] pk_h64(input hv_t h);
      logic [511:0] r;
      for (int j = 0; j < 8; j++) r[(7-j)*64 +: 64] = h[j];
      return r;
   endfunction
   function automatic hv_t up_h32(input logic [255:0] d);
      hv_t r;
      for (int j = 0; j < 8; j++) r[j] = {32'h0, d[(7-j)*32 +: 32]};
      return r;
   endfunction
   function automatic hv_t up_h64(input logic [511:0] d);
      hv_t r;
      for (int j = 0; j < 8; j++) r[j] = d[(7-j)*64 +: 64];
      return r;
   endfunction
   function automatic blk_t up_blk32(input logic [511:0] d);
      blk_t r;
      for (int j = 0; j < 16; j++) r[j] = {32'h0, d[(15-j)*32 +: 32]};
      return r;
   endfunction
   function automatic blk_t rnd_blk(input int ws);
      blk_t r;
      for (int j = 0; j < 16; j++) r[j] = (ws == 32) ? {32'h0, $urandom} : {$urandom, $urandom};
      return r;
   endfunction
   function automatic hv_t rnd_hv(input int ws);
      hv_t r;
      for (int j = 0; j < 8; j++) r[j] = (ws == 32) ? {32'h0, $urandom} : {$urandom, $urandom};
      return r;
   endfunction
   function automatic hv_t iv(input int ws);
      hv_t r;
      for (int j = 0; j < 8; j++) r[j] = (ws == 32) ? {32'h0, IV512[j][63:32]} : IV512[j];
      return r;
   endfunction
   function automatic blk_t abc(input int ws);
      blk_t r;
      r     = '0;
      r[0]  = (ws == 32) ? 64'h61626380 : 64'h6162638000000000;
      r[15] = 64'h18;
      return r;
   endfunction

   function automatic logic cur_dv(input int sel);   return sel != 0 ? s64_dv   : s32_dv;   endfunction
   function automatic logic cur_rdy(input int sel);  return sel != 0 ? s64_sr   : s32_sr;   endfunction
   function automatic logic cur_busy(input int sel); return sel != 0 ? s64_busy : s32_busy; endfunction
   function automatic logic [6:0] cur_ridx(input int sel); return sel != 0 ? s64_ridx : s32_ridx; endfunction
   function automatic logic [511:0] cur_dout(input int sel);
      return sel != 0 ? s64_dout : {256'h0, s32_dout};
   endfunction

   task automatic set_dr(input int sel, input logic v);
      if (sel != 0) s64_dr = v; else s32_dr = v;
   endtask
   task automatic set_abort(input int sel, input logic v);
      if (sel != 0) s64_abort = v; else s32_abort = v;
   endtask

   // Presents one block for a single edge, then scrambles the inputs.
   task automatic start_blk(input int sel, input hv_t h, input blk_t m, output logic rdy_seen);
      @(negedge clk);
      rdy_seen = cur_rdy(sel);
      if (sel != 0) begin s64_h = pk_h64(h); s64_blk = pk_blk64(m); s64_sv = 1'b1; end
      else begin s32_h = pk_h32(h); s32_blk = pk_blk32(m); s32_sv = 1'b1; end
      @(negedge clk);
      s64_sv = 1'b0; s32_sv = 1'b0;
      if (sel != 0) begin s64_h = pk_h64(rnd_hv(64)); s64_blk = pk_blk64(rnd_blk(64)); end
      else begin s32_h = pk_h32(rnd_hv(32)); s32_blk = pk_blk32(rnd_blk(32)); end
   endtask

   // Runs one block to its digest handshake; collects protocol violations in errs.
   task automatic run_blk(input int sel, input hv_t h, input blk_t m, input int hold,
                          input bit abt, output hv_t dig, output int lat, output int errs);
      int nr, u, cnt;
      logic rdy_seen;
      logic [511:0] held;
      logic [6:0] exp_idx;
      errs = 0;
      nr = (sel != 0) ? 20 : 64;
      u  = (sel != 0) ? 4 : 1;
      if (abt) set_abort(sel, 1'b1);
      start_blk(sel, h, m, rdy_seen);
      set_abort(sel, 1'b0);
      if (rdy_seen !== 1'b1) errs++;
      cnt = 0;
      while (cur_dv(sel) !== 1'b1 && cnt < 300) begin
         exp_idx = (cnt < nr) ? 7'(cnt * u) : 7'd0;
         if (cur_rdy(sel) !== 1'b0 || cur_busy(sel) !== 1'b1 || cur_ridx(sel) !== exp_idx) errs++;
         set_dr(sel, 1'($urandom_range(0, 1)));
         @(negedge clk);
         cnt++;
      end
      set_dr(sel, 1'b0);
      lat  = cnt;
      held = cur_dout(sel);
      dig  = (sel != 0) ? up_h64(s64_dout) : up_h32(s32_dout);
      if (abt) set_abort(sel, 1'b1);
      repeat (hold) begin
         @(negedge clk);
         if (cur_dv(sel) !== 1'b1 || cur_dout(sel) !== held || cur_rdy(sel) !== 1'b0) errs++;
      end
      set_dr(sel, 1'b1);
      @(negedge clk);
      set_dr(sel, 1'b0);
      set_abort(sel, 1'b0);
      if (cur_dv(sel) !== 1'b0 || cur_rdy(sel) !== 1'b1 || cur_busy(sel) !== 1'b0) errs++;
   endtask

   task automatic wait_idx(input int sel, input logic [6:0] target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (cur_busy(sel) === 1'b1 && cur_ridx(sel) === target) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (s32_sr !== 1'b1) begin n_fail++; $display("FAIL reset start_ready32: got %b want 1", s32_sr); end
      n_cmp++; if (s32_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy32: got %b want 0", s32_busy); end
      n_cmp++; if (s32_dv !== 1'b0) begin n_fail++; $display("FAIL reset digest_valid32: got %b want 0", s32_dv); end
      n_cmp++; if (s32_ridx !== 7'd0) begin n_fail++; $display("FAIL reset round_idx32: got %0d want 0", s32_ridx); end
      n_cmp++; if (s32_dout !== 256'h0) begin n_fail++; $display("FAIL reset digest32: got %h want 0", s32_dout); end
      n_cmp++; if (s64_sr !== 1'b1 || s64_busy !== 1'b0 || s64_dout !== 512'h0) begin
         n_fail++; $display("FAIL reset engine64: got ready=%b busy=%b dout=%h want 1 0 0", s64_sr, s64_busy, s64_dout); end
      rst_n = 1'b1;
   endtask

   task automatic test_sha256_abc();
      hv_t dig, expv; int lat, errs;
      run_blk(0, iv(32), abc(32), 0, 1'b0, dig, lat, errs);
      expv = up_h32(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
      n_cmp++; if (dig !== expv) begin n_fail++; $display("FAIL sha256 abc digest: got %h want %h", dig, expv); end
      n_cmp++; if (dig !== ref_compress(32, iv(32), abc(32))) begin n_fail++; $display("FAIL sha256 abc model: got %h want %h", dig, ref_compress(32, iv(32), abc(32))); end
      n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL sha256 latency: got %0d want 65", lat); end
      n_cmp++; if (errs !== 0) begin n_fail++; $display("FAIL sha256 protocol: got %0d errors want 0", errs); end
   endtask

   task automatic test_sha512_abc();
      hv_t dig; int lat, errs;
      run_blk(1, iv(64), abc(64), 0, 1'b0, dig, lat, errs);
      n_cmp++; if (dig[0] !== 64'hddaf35a193617aba) begin n_fail++; $display("FAIL sha512 abc head: got %h want ddaf35a193617aba", dig[0]); end
      n_cmp++; if (dig[7][31:0] !== 32'ha54ca49f) begin n_fail++; $display("FAIL sha512 abc tail: got %h want a54ca49f", dig[7][31:0]); end
      n_cmp++; if (dig !== ref_compress(64, iv(64), abc(64))) begin n_fail++; $display("FAIL sha512 abc model: got %h want %h", dig, ref_compress(64, iv(64), abc(64))); end
      n_cmp++; if (lat !== 21) begin n_fail++; $display("FAIL sha512 latency: got %0d want 21", lat); end
      n_cmp++; if (errs !== 0) begin n_fail++; $display("FAIL sha512 protocol: got %0d errors want 0", errs); end
   endtask

   task automatic test_two_block();
      hv_t d1, d2, expv; blk_t b1, b2; int lat, e1, e2;
      b1 = up_blk32(512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000);
      b2 = up_blk32(512'h1c0);
      run_blk(0, iv(32), b1, 2, 1'b0, d1, lat, e1);
      run_blk(0, d1, b2, 0, 1'b0, d2, lat, e2);
      expv = up_h32(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
      n_cmp++; if (d2 !== expv) begin n_fail++; $display("FAIL two-block digest: got %h want %h", d2, expv); end
      n_cmp++; if (d1 !== ref_compress(32, iv(32), b1)) begin n_fail++; $display("FAIL two-block first: got %h want %h", d1, ref_compress(32, iv(32), b1)); end
      n_cmp++; if (e1 + e2 !== 0) begin n_fail++; $display("FAIL two-block protocol: got %0d errors want 0", e1 + e2); end
   endtask

   task automatic test_backpressure();
      hv_t h, dig; blk_t m; int lat, errs;
      for (int s = 0; s < 2; s++) begin
         h = rnd_hv(s != 0 ? 64 : 32);
         m = rnd_blk(s != 0 ? 64 : 32);
         run_blk(s, h, m, 10, 1'b0, dig, lat, errs);
         n_cmp++; if (errs !== 0) begin n_fail++; $display("FAIL backpressure hold sel%0d: got %0d errors want 0", s, errs); end
         n_cmp++; if (dig !== ref_compress(s != 0 ? 64 : 32, h, m)) begin n_fail++; $display("FAIL backpressure digest sel%0d: got %h want %h", s, dig, ref_compress(s != 0 ? 64 : 32, h, m)); end
      end
   endtask

   task automatic test_random();
      hv_t h, dig; blk_t m; int lat, errs, ws;
      for (int it = 0; it < 4; it++) begin
         for (int s = 0; s < 2; s++) begin
            ws = (s != 0) ? 64 : 32;
            h = rnd_hv(ws);
            m = rnd_blk(ws);
            run_blk(s, h, m, int'($urandom_range(0, 3)), 1'b0, dig, lat, errs);
            n_cmp++; if (dig !== ref_compress(ws, h, m)) begin n_fail++; $display("FAIL random digest it%0d ws%0d: got %h want %h", it, ws, dig, ref_compress(ws, h, m)); end
            n_cmp++; if (lat !== ((s != 0) ? 21 : 65) || errs !== 0) begin n_fail++; $display("FAIL random protocol it%0d ws%0d: got lat=%0d errs=%0d want lat=%0d errs=0", it, ws, lat, errs, (s != 0) ? 21 : 65); end
         end
      end
   endtask

   task automatic test_abort_ignored();
      hv_t h, dig; blk_t m; int lat, errs;
      h = rnd_hv(32);
      m = rnd_blk(32);
      run_blk(0, h, m, 3, 1'b1, dig, lat, errs);
      n_cmp++; if (dig !== ref_compress(32, h, m)) begin n_fail++; $display("FAIL abort-ignored digest: got %h want %h", dig, ref_compress(32, h, m)); end
      n_cmp++; if (errs !== 0 || lat !== 65) begin n_fail++; $display("FAIL abort-ignored protocol: got errs=%0d lat=%0d want 0 65", errs, lat); end
   endtask

   task automatic test_abort();
      hv_t dig; int lat, errs, seen; bit ok; logic rdy;
      start_blk(0, iv(32), abc(32), rdy);
      wait_idx(0, 7'd30, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort reach round30: got %b want 1", ok); end
      s32_abort = 1'b1;
      @(negedge clk);
      s32_abort = 1'b0;
      n_cmp++; if (s32_busy !== 1'b0 || s32_sr !== 1'b1 || s32_dv !== 1'b0) begin
         n_fail++; $display("FAIL abort round: got busy=%b ready=%b dv=%b want 0 1 0", s32_busy, s32_sr, s32_dv); end
      seen = 0;
      repeat (70) begin @(negedge clk); if (s32_dv !== 1'b0) seen++; end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort no digest: got %0d valid cycles want 0", seen); end
      run_blk(0, iv(32), abc(32), 0, 1'b0, dig, lat, errs);
      n_cmp++; if (dig !== up_h32(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) || errs !== 0) begin
         n_fail++; $display("FAIL abort recovery: got %h errs=%0d want ba7816bf...f20015ad errs=0", dig, errs); end
      // abort in the FINAL cycle of the 4-way engine
      start_blk(1, iv(64), abc(64), rdy);
      wait_idx(1, 7'd76, ok);
      @(negedge clk);
      n_cmp++; if (ok !== 1'b1 || s64_busy !== 1'b1 || s64_ridx !== 7'd0 || s64_dv !== 1'b0) begin
         n_fail++; $display("FAIL abort final reach: got ok=%b busy=%b idx=%0d dv=%b want 1 1 0 0", ok, s64_busy, s64_ridx, s64_dv); end
      s64_abort = 1'b1;
      @(negedge clk);
      s64_abort = 1'b0;
      seen = 0;
      repeat (5) begin if (s64_dv !== 1'b0 || s64_busy !== 1'b0) seen++; @(negedge clk); end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort final: got %0d busy/valid cycles want 0", seen); end
   endtask

   task automatic test_reset_mid();
      hv_t dig; int lat, errs; bit ok; logic rdy;
      start_blk(0, rnd_hv(32), rnd_blk(32), rdy);
      wait_idx(0, 7'd10, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reset-mid reach round10: got %b want 1", ok); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (s32_busy !== 1'b0 || s32_dv !== 1'b0 || s32_ridx !== 7'd0 || s32_sr !== 1'b1) begin
         n_fail++; $display("FAIL reset-mid outputs: got busy=%b dv=%b idx=%0d ready=%b want 0 0 0 1", s32_busy, s32_dv, s32_ridx, s32_sr); end
      n_cmp++; if (s32_dout !== 256'h0 || s64_dout !== 512'h0) begin
         n_fail++; $display("FAIL reset-mid digest clear: got %h / %h want 0", s32_dout, s64_dout); end
      @(negedge clk);
      rst_n = 1'b1;
      run_blk(0, iv(32), abc(32), 0, 1'b0, dig, lat, errs);
      n_cmp++; if (dig !== up_h32(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) || lat !== 65 || errs !== 0) begin
         n_fail++; $display("FAIL reset-mid recovery: got %h lat=%0d errs=%0d want ba7816bf...f20015ad 65 0", dig, lat, errs); end
   endtask

   initial begin
      test_reset();
      test_sha256_abc();
      test_sha512_abc();
      test_two_block();
      test_backpressure();
      test_random();
      test_abort_ignored();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
